jesd_sysref_lmfc: RTL

//  Generates the LMFC (multiframe) timebase for a JESD204B link in the coreclk domain and aligns it to SYSREF.

---
 rtl/jesd_sysref_lmfc_pkg.sv | 38 +++
 rtl/jesd_sysref_lmfc_if.sv | 51 +++++
 rtl/jesd_sysref_lmfc_sync.sv | 47 ++++
 rtl/jesd_sysref_lmfc.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/jesd_sysref_lmfc_pkg.sv
// -----------------------------------------------------------------------------
// jesd_sysref_lmfc_pkg
//   Shared types and helpers for the JESD204B LMFC timebase / SYSREF aligner.
//   - sysref_mode_t : SYSREF handling mode presented on the control interface
//   - lmfc_fsm_t    : capture state machine states
//   - lmfc_period() : LMFC period in coreclk cycles for a given F, K and
//                     octets-per-lane-per-clock
// -----------------------------------------------------------------------------
package jesd_sysref_lmfc_pkg;

  // Encoding of the sysref_mode control. RESERVED behaves exactly like IGNORE.
  typedef enum logic [1:0] {
    MODE_ONESHOT    = 2'd0,
    MODE_CONTINUOUS = 2'd1,
    MODE_IGNORE     = 2'd2,
    MODE_RESERVED   = 2'd3
  } sysref_mode_t;

  // Capture FSM: free-running, waiting for a usable SYSREF edge, aligned.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } lmfc_fsm_t;

  // Width of the saturating SYSREF edge counter.
  localparam int EDGE_CNT_W = 8;

  // Width of the skip count control.
  localparam int SKIP_W = 4;

  // Multiframe length in coreclk cycles: F*K octets per multiframe per lane,
  // delivered bpc octets at a time. Callers guard against a non-integer ratio.
  function automatic int lmfc_period(input int f, input int k, input int bpc);
    return (bpc > 0) ? (f * k) / bpc : 0;
  endfunction

endpackage : jesd_sysref_lmfc_pkg

// File: rtl/jesd_sysref_lmfc_if.sv
// -----------------------------------------------------------------------------
// jesd_sysref_lmfc_if
//   Control/status bundle of the LMFC timebase block.
//   Parameter CW must equal the block's derived counter width $clog2(P).
//
//   Signals (direction seen from the block, i.e. the slave modport):
//     sysref            in   raw SYSREF from the pad, asynchronous
//     sysref_mode       in   one-shot / continuous / ignore (reserved = ignore)
//     sysref_skip       in   accepted edges discarded after arm
//     arm               in   single-cycle pulse, (re)arms capture
//     clear             in   clears sysref_misaligned
//     lmfc_cnt          out  position within the multiframe, 0..P-1
//     lmfc_pulse        out  high in every cycle where lmfc_cnt == 0
//     sysref_captured   out  high while the capture FSM is LOCKED
//     sysref_misaligned out  sticky: a checked edge disagreed with the timebase
//     sysref_edge_cnt   out  saturating count of detected SYSREF rising edges
//
//   master: the controlling side (link layer / test environment)
//   slave : the jesd_sysref_lmfc block
// -----------------------------------------------------------------------------
interface jesd_sysref_lmfc_if
  import jesd_sysref_lmfc_pkg::*;
#(
  parameter int CW = 3
) ();

  logic                  sysref;
  sysref_mode_t          sysref_mode;
  logic [SKIP_W-1:0]     sysref_skip;
  logic                  arm;
  logic                  clear;

  logic [CW-1:0]         lmfc_cnt;
  logic                  lmfc_pulse;
  logic                  sysref_captured;
  logic                  sysref_misaligned;
  logic [EDGE_CNT_W-1:0] sysref_edge_cnt;

  modport master (
    output sysref, sysref_mode, sysref_skip, arm, clear,
    input  lmfc_cnt, lmfc_pulse, sysref_captured, sysref_misaligned,
           sysref_edge_cnt
  );

  modport slave (
    input  sysref, sysref_mode, sysref_skip, arm, clear,
    output lmfc_cnt, lmfc_pulse, sysref_captured, sysref_misaligned,
           sysref_edge_cnt
  );

endinterface : jesd_sysref_lmfc_if

// File: rtl/jesd_sysref_lmfc_sync.sv
// -----------------------------------------------------------------------------
// jesd_sysref_lmfc_sync
//   Brings the asynchronous SYSREF pad signal into the coreclk domain through
//   STAGES flops and produces a registered single-cycle rising-edge strobe.
//
//   A sysref sampled high at clock edge N gives sysref_edge high in the cycle
//   after edge N+STAGES.
//
//   Ports:
//     coreclk      in   block clock
//     rst          in   asynchronous reset, active-high
//     sysref       in   raw SYSREF, asynchronous
//     sysref_edge  out  one-cycle strobe per SYSREF rising edge (registered)
// -----------------------------------------------------------------------------
module jesd_sysref_lmfc_sync #(
  parameter int STAGES = 2
) (
  input  logic coreclk,
  input  logic rst,
  input  logic sysref,
  output logic sysref_edge
);

  if (STAGES < 2) begin : g_bad_stages
    $error("jesd_sysref_lmfc_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // The synchroniser clears on reset as well, so a SYSREF that is already
  // high when reset releases is seen as a fresh rising edge.
  always_ff @(posedge coreclk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      sysref_edge <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its neighbour, which is what turns this into a shift chain.
      sync_q      <= {sync_q[STAGES-2:0], sysref};
      prev_q      <= sync_q[STAGES-1];
      sysref_edge <= sync_q[STAGES-1] & ~prev_q;
    end
  end

endmodule : jesd_sysref_lmfc_sync

// File: rtl/jesd_sysref_lmfc.sv
// -----------------------------------------------------------------------------
// jesd_sysref_lmfc
//   LMFC (multiframe) timebase for a JESD204B link in the coreclk domain,
//   aligned to SYSREF. Feeds the TX/RX cores and deterministic-latency logic.
//
//   Parameters:
//     BYTES_PER_CLK  octets per lane per coreclk cycle
//     F              octets per frame
//     K              frames per multiframe
//     SYSREF_STAGES  synchroniser depth on sysref (>= 2)
//     SYSREF_DELAY   lmfc_cnt value loaded on alignment (0..P-1)
//   Derived: P = F*K/BYTES_PER_CLK cycles per multiframe, CW = $clog2(P).
//
//   Ports:
//     coreclk  in     single clock for the whole block
//     rst      in     asynchronous reset, active-high
//     bus      slave  control/status bundle (see jesd_sysref_lmfc_if);
//                     the interface CW parameter must equal $clog2(P)
//
//   Behaviour summary:
//     - lmfc_cnt free-runs 0..P-1 and is loaded with SYSREF_DELAY on align.
//     - IDLE: free-run; arm -> ARMED (unless mode is ignore).
//     - ARMED: the first sysref_skip edges are discarded, the next aligns and
//       moves to LOCKED.
//     - LOCKED: every edge is checked against the timebase; continuous mode
//       also realigns on each edge, one-shot never does. arm -> ARMED.
//     - Ignore/reserved mode forces IDLE; edges are still counted.
//     - arm has priority over a coincident edge for alignment and skipping.
// -----------------------------------------------------------------------------
module jesd_sysref_lmfc
  import jesd_sysref_lmfc_pkg::*;
#(
  parameter int BYTES_PER_CLK = 4,
  parameter int F             = 1,
  parameter int K             = 32,
  parameter int SYSREF_STAGES = 2,
  parameter int SYSREF_DELAY  = 0
) (
  input logic                coreclk,
  input logic                rst,
  jesd_sysref_lmfc_if.slave  bus
);

  localparam int P  = lmfc_period(F, K, BYTES_PER_CLK);
  localparam int CW = (P < 2) ? 1 : $clog2(P);

  localparam logic [CW-1:0] CNT_LAST  = CW'(P - 1);
  localparam logic [CW-1:0] CNT_ALIGN = CW'(SYSREF_DELAY);
  localparam logic [EDGE_CNT_W-1:0] EDGE_CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Parameter sanity
  // ---------------------------------------------------------------------------
  if (BYTES_PER_CLK < 1 || ((F * K) % BYTES_PER_CLK) != 0) begin : g_bad_ratio
    $error("jesd_sysref_lmfc: F*K must be a multiple of BYTES_PER_CLK");
  end
  if (P < 2) begin : g_bad_period
    $error("jesd_sysref_lmfc: LMFC period must be at least 2 cycles");
  end
  if (SYSREF_DELAY < 0 || SYSREF_DELAY >= P) begin : g_bad_delay
    $error("jesd_sysref_lmfc: SYSREF_DELAY must lie in 0..P-1");
  end

  // ---------------------------------------------------------------------------
  // SYSREF synchroniser and edge detect
  // ---------------------------------------------------------------------------
  logic sysref_edge;

  jesd_sysref_lmfc_sync #(
    .STAGES (SYSREF_STAGES)
  ) u_sync (
    .coreclk     (coreclk),
    .rst         (rst),
    .sysref      (bus.sysref),
    .sysref_edge (sysref_edge)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  lmfc_fsm_t             state;
  logic [SKIP_W-1:0]     skip_cnt;
  logic [CW-1:0]         cnt_q;
  logic                  pulse_q;
  logic                  captured_q;
  logic                  misaligned_q;
  logic [EDGE_CNT_W-1:0] edge_cnt_q;

  logic ignore_mode;
  assign ignore_mode = (bus.sysref_mode == MODE_IGNORE) ||
                       (bus.sysref_mode == MODE_RESERVED);

  // ---------------------------------------------------------------------------
  // Next-count, alignment and check decisions
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_free;      // where the counter goes if left alone
  logic [CW-1:0] cnt_next;
  logic          align;
  logic          misalign_set;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    cnt_free     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    align        = 1'b0;
    misalign_set = 1'b0;

    // The check uses the pre-realign position: an edge is in phase when the
    // free-running counter would land on SYSREF_DELAY this very cycle.
    if (state == LOCKED && sysref_edge) begin
      misalign_set = (cnt_free != CNT_ALIGN);
    end

    // arm and ignore both pre-empt an alignment in the same cycle.
    if (sysref_edge && !ignore_mode && !bus.arm) begin
      unique case (state)
        ARMED:   align = (skip_cnt >= bus.sysref_skip);
        LOCKED:  align = (bus.sysref_mode == MODE_CONTINUOUS);
        default: align = 1'b0;
      endcase
    end

    cnt_next = align ? CNT_ALIGN : cnt_free;
  end

  // ---------------------------------------------------------------------------
  // Capture FSM with registered captured flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge coreclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      skip_cnt   <= '0;
      captured_q <= 1'b0;
    end else if (ignore_mode) begin
      state      <= IDLE;
      captured_q <= 1'b0;
    end else if (bus.arm) begin
      // Re-arming from any state restarts the skip count.
      state      <= ARMED;
      skip_cnt   <= '0;
      captured_q <= 1'b0;
    end else if (state == ARMED && sysref_edge) begin
      if (skip_cnt < bus.sysref_skip) begin
        skip_cnt <= skip_cnt + 1'b1;
      end else begin
        state      <= LOCKED;
        captured_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // LMFC counter and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge coreclk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      pulse_q      <= 1'b0;
      misaligned_q <= 1'b0;
      edge_cnt_q   <= '0;
    end else begin
      cnt_q   <= cnt_next;
      // Derived from cnt_next so the pulse lines up with lmfc_cnt == 0.
      pulse_q <= (cnt_next == '0);

      // A new misalignment outranks a clear in the same cycle.
      if (misalign_set) begin
        misaligned_q <= 1'b1;
      end else if (bus.clear) begin
        misaligned_q <= 1'b0;
      end

      if (sysref_edge && edge_cnt_q != EDGE_CNT_MAX) begin
        edge_cnt_q <= edge_cnt_q + 1'b1;
      end
    end
  end

  assign bus.lmfc_cnt          = cnt_q;
  assign bus.lmfc_pulse        = pulse_q;
  assign bus.sysref_captured   = captured_q;
  assign bus.sysref_misaligned = misaligned_q;
  assign bus.sysref_edge_cnt   = edge_cnt_q;

endmodule : jesd_sysref_lmfc
